// File: rtl/serial_bit_reverser_pkg.sv
// Shared types and constants for the bit-serial word reverser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_bit_reverser_pkg;

    // Default data word width; the datapath assumes a power of two, at least 2.
    localparam int WIDTH_DEF = 16;

    // Controller states. Encoding 2'd3 is unused and is treated as IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Repack direction captured alongside the source word.
    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_REV  = 1'b1;

    // True when v is a power of two no smaller than 2.
    function automatic logic is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage : serial_bit_reverser_pkg

// File: rtl/btr_shift_acc.sv
// Source/accumulator shift pair: unpacks src LSB first, repacks into acc.
// Latency: one bit per shift cycle; WIDTH shifts per word, last flags the final one.
// Backpressure: none; load and shift are driven by the controller and never stall.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        capture load_dat into src, clear acc and cnt
//   shift       move one bit from src[0] into acc
//   dir         MODE_REV: shift acc left (reverse); MODE_PASS: shift acc right (pass)
//   load_dat    source word
//   acc_nxt     value acc takes at the coming edge (includes the bit shifted now)
//   last        high while the shift in progress is the final one (cnt == WIDTH-1)
module btr_shift_acc
    import serial_bit_reverser_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_dat,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             last
);

    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        src_d = src_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            src_d = load_dat;
            acc_d = '0;
            cnt_d = '0;
        end else if (shift) begin
            src_d = src_q >> 1;
            // Left shift lands the first-unpacked LSB in the MSB after WIDTH
            // steps (reversal); right shift lands it back in the LSB (pass).
            if (dir == MODE_REV) begin
                acc_d = {acc_q[WIDTH-2:0], src_q[0]};
            end else begin
                acc_d = {src_q[0], acc_q[WIDTH-1:1]};
            end
            // Free-running wrap back to 0 after the final shift.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_nxt = acc_d;
    assign last    = (cnt_q == CNT_W'(WIDTH - 1));

endmodule : btr_shift_acc

// File: rtl/serial_bit_reverser.sv
// Bit-serial word reverser / pass-through with start/busy/done handshake.
// Latency: done in the cycle after the WIDTH-th shift edge; one word per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset (clears out as well)
//   start     request, accepted only in IDLE
//   in        source word, captured when start is accepted
//   en        1 = bit-reverse, 0 = pass-through; captured with in
//   busy      high in SHIFT and DONE
//   done      one-cycle pulse, out valid
//   out       result register, updated only at completion
module serial_bit_reverser
    import serial_bit_reverser_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    if (!is_pow2(WIDTH)) begin : g_width_check
        $error("serial_bit_reverser: WIDTH must be a power of two, at least 2");
    end

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic             in_idle;
    logic             in_shift;
    logic             in_done;
    logic             sa_load;
    logic [WIDTH-1:0] sa_acc_nxt;
    logic             sa_last;

    // Any encoding other than SHIFT/DONE behaves as IDLE, so a corrupted
    // state register recovers on the next edge.
    assign in_shift = (state_q == SHIFT);
    assign in_done  = (state_q == DONE);
    assign in_idle  = !in_shift && !in_done;

    assign sa_load  = in_idle && start;

    btr_shift_acc #(
        .WIDTH (WIDTH)
    ) u_shift_acc (
        .clk      (clk),
        .rst      (rst),
        .load     (sa_load),
        .shift    (in_shift),
        .dir      (mode_q),
        .load_dat (in),
        .acc_nxt  (sa_acc_nxt),
        .last     (sa_last)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        out_d   = out_q;
        if (in_shift) begin
            if (sa_last) begin
                // Publish the completed word, including the bit shifted now.
                out_d   = sa_acc_nxt;
                state_d = DONE;
            end
        end else if (in_done) begin
            state_d = IDLE;
        end else begin
            state_d = IDLE;
            if (start) begin
                mode_d  = en;
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_PASS;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign busy = in_shift || in_done;
    assign done = in_done;
    assign out  = out_q;

endmodule : serial_bit_reverser

// File: tb/tb_serial_bit_reverser.sv
// Directed bench for serial_bit_reverser (WIDTH = 16).
// Inputs driven and outputs sampled on the falling edge, away from the active edge.
// Every wait on done is bounded; a timeout shows up as a latency mismatch.
module tb_serial_bit_reverser;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_dat;
    logic        en;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          lat;
    int          gap;
    int          n_done;
    logic [15:0] res;

    serial_bit_reverser #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_dat),
        .en    (en),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the first falling edge after the accepting edge; returns the
    // number of further falling edges until done is seen (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Issue one request, wait for done, return out and latency; leaves the
    // bench at the falling edge after the DONE cycle (back in IDLE).
    task automatic run_op(input logic [15:0] d, input logic m,
                          output logic [15:0] r, output int cycles);
        @(negedge clk);
        in_dat = d;
        en     = m;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(cycles);
        r = out;
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        in_dat = '0;
        en     = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out",  {16'd0, out},  32'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Scenario 1: 0x0001 reversed, with cycle-exact handshake checks.
        @(negedge clk);
        in_dat = 16'h0001;
        en     = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk("s1_busy_after_e0", {31'd0, busy}, 32'd1);
        chk("s1_done_after_e0", {31'd0, done}, 32'd0);
        chk("s1_out_not_early", {16'd0, out},  32'h0000);
        wait_done(lat);
        chk("s1_latency",       lat,           32'd16);
        chk("s1_out",           {16'd0, out},  32'h8000);
        chk("s1_busy_in_done",  {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("s1_busy_after",    {31'd0, busy}, 32'd0);
        chk("s1_done_after",    {31'd0, done}, 32'd0);
        chk("s1_out_hold",      {16'd0, out},  32'h8000);

        // Scenario 2: reversal and its involution.
        run_op(16'hA5C3, 1'b1, res, lat);
        chk("rev_a5c3",     {16'd0, res}, 32'hC3A5);
        chk("rev_a5c3_lat", lat,          32'd16);
        run_op(16'hC3A5, 1'b1, res, lat);
        chk("rev_involute", {16'd0, res}, 32'hA5C3);

        // Scenario 3: pass-through and all-ones / all-zeros in both modes.
        run_op(16'h1234, 1'b0, res, lat);
        chk("pass_1234",     {16'd0, res}, 32'h1234);
        chk("pass_1234_lat", lat,          32'd16);
        run_op(16'hFFFF, 1'b1, res, lat);
        chk("rev_ffff",      {16'd0, res}, 32'hFFFF);
        run_op(16'h0000, 1'b1, res, lat);
        chk("rev_0000",      {16'd0, res}, 32'h0000);
        run_op(16'hFFFF, 1'b0, res, lat);
        chk("pass_ffff",     {16'd0, res}, 32'hFFFF);
        run_op(16'h0000, 1'b0, res, lat);
        chk("pass_0000",     {16'd0, res}, 32'h0000);

        // Scenario 4: start/in/en disturbed mid-operation must not matter.
        @(negedge clk);
        in_dat = 16'h0001;
        en     = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        in_dat = 16'hFFFF;
        en     = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        in_dat = 16'h5555;
        en     = 1'b1;
        wait_done(lat);
        chk("midop_latency", lat,          32'd11);
        chk("midop_out",     {16'd0, out}, 32'h8000);
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("midop_no_second_done", n_done,        32'd0);
        chk("midop_out_hold",       {16'd0, out},  32'h8000);

        // Scenario 5: start held high -> one word every 18 cycles.
        @(negedge clk);
        in_dat = 16'h0003;
        en     = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        wait_done(lat);
        chk("held_first_lat", lat,          32'd16);
        chk("held_out_1",     {16'd0, out}, 32'hC000);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (done !== 1'b1 && gap < 40);
        chk("held_period",    gap,          32'd18);
        chk("held_out_2",     {16'd0, out}, 32'hC000);
        start = 1'b0;
        @(negedge clk);
        chk("held_idle_after", {31'd0, busy}, 32'd0);

        // Scenario 6: asynchronous reset after the 8th shift.
        run_op(16'hA5C3, 1'b1, res, lat);
        chk("pre_rst_out", {16'd0, out}, 32'hC3A5);
        @(negedge clk);
        in_dat = 16'h1234;
        en     = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_out",  {16'd0, out},  32'h0000);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_out_held", {16'd0, out}, 32'h0000);
        run_op(16'h8000, 1'b1, res, lat);
        chk("post_rst_out", {16'd0, res}, 32'h0001);
        chk("post_rst_lat", lat,          32'd16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_serial_bit_reverser

// File: doc/serial_bit_reverser.md
Name:
serial_bit_reverser

Overview:
- Multi-cycle, bit-serial counterpart to the combinational 16-bit word bit-reverse stage.
- Unpacks a latched source word one bit per cycle, LSB first, and repacks it into an accumulator.
- With reverse mode set, the repacked word is the source bit-reversed; with it clear, the word passes through unchanged.
- Sits beside the ALU or shifter as a low-area option for the BTR-type path, with a start/busy/done handshake to the controller.

Parameters:
- WIDTH, 16, data word width; must be a power of two, at least 2.
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- in  input  WIDTH  source word; captured on the edge where start is accepted.
- en  input  1  reverse mode: 1 = bit-reverse, 0 = pass-through; captured with in.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; out is valid.
- out  output  WIDTH  result register; holds its value until the next completion.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - src, acc, cnt, out = 0.
  - busy = 0, done = 0.
- States are IDLE, SHIFT and DONE. All outputs are registered or decoded from state.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1 at an edge (E0): src <= in, mode <= en, acc <= 0, cnt <= 0, go to SHIFT.
  - If start = 0: remain in IDLE.
- SHIFT, one bit per edge:
  - src <= src >> 1.
  - mode = 1: acc <= {acc[WIDTH-2:0], src[0]} (shift left, new bit into LSB).
  - mode = 0: acc <= {src[0], acc[WIDTH-1:1]} (shift right, new bit into MSB).
  - cnt <= cnt + 1. cnt wraps to 0 on the last shift; no overflow state.
  - At the edge where cnt == WIDTH-1, the shift completes. In that same edge, out <= the final acc value (including that last bit) and the state goes to DONE.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle.
  - Next edge: go to IDLE unconditionally.
- Latency, with start accepted at E0:
  - Shifts occur at E1 through E{WIDTH}.
  - done is high in the cycle after E{WIDTH} (E16 for WIDTH = 16).
  - busy is high from E0 to E{WIDTH+1}.
  - The next start is accepted no earlier than E{WIDTH+1} (IDLE).
- start while busy (SHIFT or DONE) is ignored; no queuing.
- Changes to in or en after E0 have no effect on the current operation.
- out changes only at completion. Mid-operation accumulator values are never visible on out.
- Reset mid-operation: abort immediately, and out is cleared to 0 (the prior result is lost).
- Reversal is an involution: feeding out back in with en = 1 restores the original word.
- Throughput: one word per WIDTH+2 cycles when start is held high.

Decomposition:
- Shared package holds:
  - WIDTH default constant.
  - State enum {IDLE, SHIFT, DONE}, 2-bit encoding, values 0, 1 and 2; encoding 3 decodes to IDLE.
  - Mode constants MODE_PASS = 0 and MODE_REV = 1.
- One natural sub-module, btr_shift_acc:
  - Owns src, acc and cnt.
  - Inputs: load, shift, dir.
  - Outputs: acc, last (cnt == WIDTH-1).
- The top module holds the FSM, the out register and the output decode.

Test Plan:
- Reset, then in = 0x0001, en = 1, start pulsed at E0 -> busy goes high; done high only in the cycle after E16; out = 0x8000; busy low after E17.
- in = 0xA5C3, en = 1 -> out = 0xC3A5. Then in = 0xC3A5, en = 1 -> out = 0xA5C3 (involution).
- in = 0x1234, en = 0 -> out = 0x1234 after the same 16-shift latency. Also 0xFFFF and 0x0000 in both modes -> unchanged.
- During SHIFT, pulse start with in = 0xFFFF, and change in and en mid-operation -> result stays that of the original request (0x8000 for the first scenario). No second done occurs.
- start held high continuously with in = 0x0003, en = 1 -> out = 0xC000. done pulses every 18 cycles.
- After a completed result out = 0xC3A5, start a new operation and assert rst asynchronously between clock edges after the 8th shift -> busy, done and out go to 0 immediately. Then a new start with in = 0x8000, en = 1 -> out = 0x0001 with the full latency.
